despacho_demux_ctrl: RTL
========================

Name: despacho_demux_ctrl

Overview:
Sequencing controller for the parameterised demultiplexor.
- Accepts one data word at a time from a producer over a valid/ready handshake.
- Selects a destination: either the fixed destination requested with the word, or a round-robin choice among ready destinations.
- Drives the demultiplexor's Entrada/SEL for exactly one cycle when the chosen destination is ready.
- Drops the word and flags a timeout if no destination becomes ready in time. SEL=0 is the idle/no-output code, so destination 0 is never used.

Parameters:
ANCHO, 9, data word width (matches demultiplexor ANCHO).
N, 2, select width; usable destinations are 1..2**N-1.
TIMEOUT, 15, max cycles a word may wait in ESPERA before being dropped; must be >= 1.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  producer has a word.
in_ready  output  1  controller can accept a word.
in_dato  input  ANCHO  data word.
in_dest  input  N  requested destination; 0 = automatic round-robin.
dest_ready  input  2**N  per-destination ready; bit 0 ignored.
Entrada  output  ANCHO  to demultiplexor Entrada.
SEL  output  N  to demultiplexor SEL; 0 = no output.
entregado  output  1  one-cycle pulse: word delivered this cycle.
error_to  output  1  one-cycle pulse: word dropped on timeout.
ocupado  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, SEL=0, Entrada=0, entregado=0, error_to=0.
  - ptr=2**N-1, wait counter=0, held word/destination cleared.
  - in_ready=0 while rst_n is low.
  - Reset mid-operation discards the held word with no entregado or error_to pulse.
- States: IDLE, ESPERA, ENVIO, DESCARTE. All outputs except in_ready are Moore (state/registers only).
- IDLE:
  - in_ready=1, SEL=0, Entrada=0.
  - On in_valid (handshake at cycle t): latch in_dato, in_dest and modo_auto=(in_dest==0), clear counter, go to ESPERA at t+1.
- ESPERA: in_ready=0, SEL=0.
  - Fixed mode: the word is eligible if dest_ready[dest] is high.
  - Auto mode: the target is the first index with dest_ready high, scanning ptr+1, ptr+2, ... over 1..2**N-1 with wrap (2**N-1 -> 1, index 0 skipped).
  - If a target is eligible: latch it and go to ENVIO.
  - Otherwise: counter++. When the counter reaches TIMEOUT (i.e., TIMEOUT ineligible ESPERA cycles), go to DESCARTE.
- ENVIO: exactly one cycle.
  - SEL=target, Entrada=held word, entregado=1.
  - In auto mode, ptr<=target; in fixed mode, ptr is unchanged.
  - Next state IDLE.
- DESCARTE: exactly one cycle.
  - error_to=1, SEL=0, Entrada=0.
  - ptr unchanged, word discarded. Next state IDLE.
- Latency: handshake at t with target ready at t+1 gives SEL/entregado at t+2. The next handshake is possible at t+3.
- Maximum occupancy per word: TIMEOUT+2 cycles (ESPERA x TIMEOUT, DESCARTE, then IDLE).
- dest_ready may change at any time; only the ESPERA-cycle sample that selects the target matters. The target is not re-checked in ENVIO.
- in_dato/in_dest changing while not in IDLE have no effect.
- Counter width is clog2(TIMEOUT+1); no wrap is possible.
- entregado and error_to are never high in the same cycle.
- SEL is nonzero only in ENVIO.

Test Plan:
1. Reset then fixed destination: in_dest=2, in_dato=9'h1A5, dest_ready=4'b0100 held. Handshake at t -> SEL=2, Entrada=9'h1A5, entregado=1 at t+2 only; SEL=0 at t+1 and t+3; in_ready=1 again at t+3.
2. Round-robin: dest_ready=4'b1110 held, three auto words (in_dest=0) back-to-back -> SEL sequence 1,2,3, then a fourth word gives 1; ptr wraps and 0 is never selected.
3. Round-robin skip: ptr=1, dest_ready=4'b1010 -> next auto word goes to 3, then the next goes to 1.
4. Timeout, TIMEOUT=4: fixed in_dest=3 with dest_ready=0 -> ESPERA t+1..t+4, error_to=1 at t+5, IDLE/in_ready=1 at t+6, entregado never high, ptr unchanged.
5. Late ready: TIMEOUT=4, dest_ready[1] rises during the 4th ESPERA cycle (t+4) -> ENVIO at t+5 with SEL=1, no error_to.
6. Reset mid-operation: assert rst_n=0 asynchronously during ESPERA -> SEL=0, in_ready=0 immediately; after release, IDLE with no entregado/error_to, and the first auto word goes to destination 1.

Source files
------------

// File: rtl/despacho_demux_ctrl.sv
// Sequencing controller for the parameterised demultiplexor: takes one word per
// valid/ready handshake and delivers it to a fixed or round-robin destination.
module despacho_demux_ctrl #(
  parameter int ANCHO   = 9,
  parameter int N       = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ANCHO-1:0]  in_dato,
  input  logic [N-1:0]      in_dest,
  input  logic [2**N-1:0]   dest_ready,
  output logic [ANCHO-1:0]  Entrada,
  output logic [N-1:0]      SEL,
  output logic              entregado,
  output logic              error_to,
  output logic              ocupado
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0]    MAX_DEST = '1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ESPERA,
    ENVIO,
    DESCARTE
  } estado_t;

  estado_t            state_q;
  logic [ANCHO-1:0]   dato_q;
  logic [N-1:0]       dest_q;
  logic               auto_q;
  logic [CW-1:0]      cnt_q;
  logic [N-1:0]       ptr_q;
  logic [N-1:0]       sel_q;
  logic [ANCHO-1:0]   entrada_q;
  logic               entregado_q;
  logic               error_q;

  logic [N-1:0]       scan_idx;
  logic [N-1:0]       rr_tgt;
  logic               rr_hit;
  logic               elig;
  logic [N-1:0]       tgt_d;
  logic [CW-1:0]      cnt_d;

  // Round-robin scan starting just after ptr; index 0 is the idle code and is skipped.
  // NOTE: every variable in always_comb gets a default first so no latch is inferred.
  always_comb begin
    scan_idx = ptr_q;
    rr_hit   = 1'b0;
    rr_tgt   = '0;
    for (int k = 1; k < 2**N; k++) begin
      scan_idx = (scan_idx == MAX_DEST) ? N'(1) : scan_idx + N'(1);
      if (!rr_hit && dest_ready[scan_idx]) begin
        rr_hit = 1'b1;
        rr_tgt = scan_idx;
      end
    end
  end

  assign elig  = auto_q ? rr_hit : dest_ready[dest_q];
  assign tgt_d = auto_q ? rr_tgt : dest_q;
  assign cnt_d = cnt_q + CW'(1);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dato_q      <= '0;
      dest_q      <= '0;
      auto_q      <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= MAX_DEST;
      sel_q       <= '0;
      entrada_q   <= '0;
      entregado_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      entregado_q <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dato_q  <= in_dato;
            dest_q  <= in_dest;
            auto_q  <= (in_dest == '0);
            cnt_q   <= '0;
            state_q <= ESPERA;
          end
        end
        ESPERA: begin
          if (elig) begin
            sel_q       <= tgt_d;
            entrada_q   <= dato_q;
            entregado_q <= 1'b1;
            state_q     <= ENVIO;
          end else if (cnt_d == CNT_LAST) begin
            cnt_q   <= cnt_d;
            dato_q  <= '0;
            error_q <= 1'b1;
            state_q <= DESCARTE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ENVIO: begin
          // The pointer only advances for words that were routed automatically.
          if (auto_q) begin
            ptr_q <= sel_q;
          end
          sel_q     <= '0;
          entrada_q <= '0;
          dato_q    <= '0;
          state_q   <= IDLE;
        end
        DESCARTE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign ocupado   = (state_q != IDLE);
  assign SEL       = sel_q;
  assign Entrada   = entrada_q;
  assign entregado = entregado_q;
  assign error_to  = error_q;

endmodule
